// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: runs a golden pass followed by one pass per fault point against an
// fp/toggle-window instrumented DUT. It drives the DUT's reset/enable/fp and builds a
// per-fault-point detection map.
// Optional build macro FC_CYCLE_CMP_EN: the golden pass records a per-cycle output trace,
// and each fault pass is compared against that trace on every cycle instead of only at the end.
module fault_campaign_ctrl #(
    parameter int unsigned FP_W       = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_FP     = 8,
    parameter int unsigned RUN_CYCLES = 16,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              dut_reset,
    output logic              dut_enable,
    output logic [FP_W-1:0]   dut_fp,
    input  logic [DATA_W-1:0] dut_out,
    output logic [DATA_W-1:0] golden_val,
    output logic [FP_W-1:0]   cur_fp,
    output logic [NUM_FP-1:0] detected,
    output logic [FP_W:0]     detect_cnt
);

    localparam int unsigned     CntW    = $clog2(RUN_CYCLES + 1);
    localparam logic [FP_W-1:0] FpNone  = '1;
    localparam logic [FP_W-1:0] FpLast  = FP_W'(NUM_FP - 1);
    localparam logic [FP_W-1:0] FpOne   = FP_W'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(RUN_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [FP_W:0]   DetOne  = (FP_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StCheck,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [FP_W-1:0]   cur_fp_q, cur_fp_d;
    logic [DATA_W-1:0] golden_q, golden_d;
    logic [NUM_FP-1:0] det_q, det_d;
    logic [FP_W:0]     det_cnt_q, det_cnt_d;
    logic              golden_run;
    logic              mismatch;

    // The all-ones fault point marks the golden pass.
    assign golden_run = (cur_fp_q == FpNone);

`ifdef FC_CYCLE_CMP_EN
    logic [DATA_W-1:0] trace_q [RUN_CYCLES+1];
    logic              run_mm_q;
    logic              cyc_diff;

    // cnt_q indexes RUN cycles 0..RUN_CYCLES-1 and equals RUN_CYCLES during CHECK.
    assign cyc_diff = (dut_out != trace_q[cnt_q]);
    assign mismatch = run_mm_q | cyc_diff;

    // Capture the golden pass output on every RUN cycle and on CHECK
    always_ff @(posedge clk) begin
        if (golden_run && ((state_q == StRun) || (state_q == StCheck))) begin
            trace_q[cnt_q] <= dut_out;
        end
    end

    // Sticky flag: some RUN cycle of the current fault pass left the golden trace
    always_ff @(posedge clk) begin
        if (reset || (state_q == StRst)) begin
            run_mm_q <= 1'b0;
        end else if ((state_q == StRun) && !golden_run && cyc_diff) begin
            run_mm_q <= 1'b1;
        end
    end
`else
    assign mismatch = (dut_out != golden_q);
`endif

    // Sequencer next-state, bookkeeping and DUT drive
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        cur_fp_d   = cur_fp_q;
        golden_d   = golden_q;
        det_d      = det_q;
        det_cnt_d  = det_cnt_q;
        busy       = 1'b0;
        done       = 1'b0;
        dut_reset  = 1'b1;
        dut_enable = 1'b0;
        dut_fp     = FpNone;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRst;
                    det_d     = '0;
                    det_cnt_d = '0;
                    cur_fp_d  = FpNone;
                end
            end
            StRst: begin
                busy    = 1'b1;
                dut_fp  = cur_fp_q;
                lfsr_d  = SEED;
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                busy       = 1'b1;
                dut_reset  = 1'b0;
                dut_enable = lfsr_q[0];
                dut_fp     = cur_fp_q;
                // x^8+x^6+x^5+x^4+1, shifting towards the MSB
                lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                cnt_d      = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                busy      = 1'b1;
                dut_reset = 1'b0;
                dut_fp    = cur_fp_q;
                if (golden_run) begin
                    golden_d = dut_out;
                    cur_fp_d = '0;
                    state_d  = StRst;
                end else begin
                    for (int unsigned i = 0; i < NUM_FP; i++) begin
                        if (cur_fp_q == FP_W'(i)) begin
                            det_d[i] = mismatch;
                        end
                    end
                    if (mismatch) begin
                        det_cnt_d = det_cnt_q + DetOne;
                    end
                    if (cur_fp_q == FpLast) begin
                        state_d = StDone;
                    end else begin
                        cur_fp_d = cur_fp_q + FpOne;
                        state_d  = StRst;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            cur_fp_q  <= FpNone;
            golden_q  <= '0;
            det_q     <= '0;
            det_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            cur_fp_q  <= cur_fp_d;
            golden_q  <= golden_d;
            det_q     <= det_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    assign golden_val = golden_q;
    assign cur_fp     = cur_fp_q;
    assign detected   = det_q;
    assign detect_cnt = det_cnt_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Scoreboard bench for fault_campaign_ctrl: a configurable stub DUT, a reference model
// computed from the campaign rules, and a done-triggered monitor.
module tb_fault_campaign_ctrl;

    localparam int FP_W   = 8;
    localparam int DATA_W = 8;
    localparam int NUM_FP = 8;
    localparam int RUN    = 16;
    localparam int LAT    = (NUM_FP + 1) * (RUN + 2) + 1;
    localparam int LAT1   = 2 * (RUN + 2) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start;
    logic              busy, done, dut_reset, dut_enable;
    logic [FP_W-1:0]   dut_fp, cur_fp;
    logic [DATA_W-1:0] dut_out, golden_val;
    logic [NUM_FP-1:0] detected;
    logic [FP_W:0]     detect_cnt;

    fault_campaign_ctrl #(
        .FP_W(FP_W), .DATA_W(DATA_W), .NUM_FP(NUM_FP), .RUN_CYCLES(RUN), .SEED(8'hA5)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .dut_reset(dut_reset), .dut_enable(dut_enable), .dut_fp(dut_fp), .dut_out(dut_out),
        .golden_val(golden_val), .cur_fp(cur_fp), .detected(detected), .detect_cnt(detect_cnt)
    );

    // Single-fault-point instance driving a counter whose enable is inverted at fp 0
    logic       start1, busy1, done1, dr1, de1;
    logic [7:0] fp1, out1, gold1, cfp1, c1;
    logic [0:0] det1;
    logic [8:0] dc1;

    fault_campaign_ctrl #(
        .FP_W(8), .DATA_W(8), .NUM_FP(1), .RUN_CYCLES(RUN), .SEED(8'hA5)
    ) u_one (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .dut_reset(dr1), .dut_enable(de1), .dut_fp(fp1), .dut_out(out1),
        .golden_val(gold1), .cur_fp(cfp1), .detected(det1), .detect_cnt(dc1)
    );

    always @(posedge clk) begin
        if (dr1) c1 <= 8'h00;
        else if (de1 ^ (fp1 == 8'h00)) c1 <= c1 + 8'h01;
    end
    assign out1 = c1;

    // Stub DUT configuration
    logic              use_cnt;
    logic [7:0]        const_gold;
    logic [7:0]        const_tab [NUM_FP];
    logic [NUM_FP-1:0] inv_mask;
    logic [7:0]        g_fp, g_cyc, g_mask;

    // Stub DUT: counter of (enable ^ inv) or a per-fp constant, plus a one-cycle glitch
    logic [7:0] s_cnt, s_cyc, s_base;
    logic       s_inv;
    always_comb s_inv = (dut_fp < 8'(NUM_FP)) ? inv_mask[dut_fp[2:0]] : 1'b0;
    always @(posedge clk) begin
        if (dut_reset) begin
            s_cnt <= 8'h00;
            s_cyc <= 8'h00;
        end else begin
            s_cyc <= s_cyc + 8'h01;
            if (dut_enable ^ s_inv) s_cnt <= s_cnt + 8'h01;
        end
    end
    always_comb begin
        s_base  = use_cnt ? s_cnt :
                  ((dut_fp < 8'(NUM_FP)) ? const_tab[dut_fp[2:0]] : const_gold);
        dut_out = s_base ^ (((dut_fp == g_fp) && (s_cyc == g_cyc)) ? g_mask : 8'h00);
    end

    // Reference model
    bit en_seq [RUN];

    function automatic void build_stimulus();
        logic [7:0] lf;
        lf = 8'hA5;
        for (int j = 0; j < RUN; j++) begin
            en_seq[j] = lf[0];
            lf = {lf[6:0], ^(lf & 8'hB8)};
        end
    endfunction

    // Stub output in cycle c after reset release of a run with fault point fp (-1 = golden)
    function automatic logic [7:0] ref_out(input int fp, input int c);
        int         n;
        bit         inv;
        logic [7:0] v, code;
        inv  = (fp >= 0) ? inv_mask[fp] : 1'b0;
        code = (fp >= 0) ? 8'(fp) : 8'hFF;
        n    = 0;
        if (use_cnt) begin
            for (int j = 0; j < c; j++) if (en_seq[j] != inv) n++;
            v = 8'(n);
        end else begin
            v = (fp >= 0) ? const_tab[fp] : const_gold;
        end
        if ((g_fp == code) && (g_cyc == 8'(c))) v = v ^ g_mask;
        return v;
    endfunction

    typedef struct {
        logic [7:0]        gold;
        logic [NUM_FP-1:0] det;
        logic [8:0]        cnt;
        int                done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests, n_fail;
    int   cyc_no = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model_campaign();
        exp_t e;
        bit   diff;
        e.gold = ref_out(-1, RUN);
        e.det  = '0;
        e.cnt  = '0;
        for (int fp = 0; fp < NUM_FP; fp++) begin
            diff = 1'b0;
`ifdef FC_CYCLE_CMP_EN
            for (int c = 0; c <= RUN; c++) if (ref_out(fp, c) != ref_out(-1, c)) diff = 1'b1;
`else
            diff = (ref_out(fp, RUN) != e.gold);
`endif
            e.det[fp] = diff;
            if (diff) e.cnt = e.cnt + 9'd1;
        end
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", 32'(cyc_no), 32'(mon_e.done_cyc));
                check("golden_val", 32'(golden_val), 32'(mon_e.gold));
                check("detected", 32'(detected), 32'(mon_e.det));
                check("detect_cnt", 32'(detect_cnt), 32'(mon_e.cnt));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic set_const(input logic [7:0] v);
        use_cnt    = 1'b0;
        const_gold = v;
        for (int i = 0; i < NUM_FP; i++) const_tab[i] = v;
        inv_mask = '0;
        g_fp     = 8'hFF;
        g_cyc    = 8'h00;
        g_mask   = 8'h00;
    endtask

    task automatic rand_cfg();
        use_cnt    = 1'($urandom_range(0, 1));
        const_gold = 8'($urandom);
        for (int i = 0; i < NUM_FP; i++)
            const_tab[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : const_gold;
        inv_mask = NUM_FP'($urandom);
        g_fp     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, NUM_FP - 1));
        g_cyc    = 8'($urandom_range(0, RUN));
        g_mask   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    endtask

    // Launch one campaign; optionally hammer start while busy and during DONE
    task automatic run_campaign(input bit hammer);
        exp_t e;
        e = model_campaign();
        @(negedge clk);
        start      = 1'b1;
        e.done_cyc = cyc_no + LAT;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (hammer) begin
            repeat (LAT - 5) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            while (cyc_no < e.done_cyc) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            while (cyc_no < e.done_cyc + 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    // Single-fault-point campaign on the counter DUT
    task automatic run_one();
        int  c0, dcyc, k, waited;
        bit  got, exp_det;
        k = 0;
        for (int j = 0; j < RUN; j++) if (en_seq[j]) k++;
        exp_det = 1'b0;
`ifdef FC_CYCLE_CMP_EN
        begin
            int n;
            n = 0;
            for (int c = 0; c <= RUN; c++) begin
                if (n != (c - n)) exp_det = 1'b1;
                if (c < RUN && en_seq[c]) n++;
            end
        end
`else
        exp_det = (k != RUN - k);
`endif
        @(negedge clk);
        start1 = 1'b1;
        c0     = cyc_no;
        @(negedge clk);
        start1 = 1'b0;
        got    = 1'b0;
        dcyc   = 0;
        waited = 0;
        while (!got && waited < LAT1 + 20) begin
            if (done1) begin
                got  = 1'b1;
                dcyc = cyc_no;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        check("one_done_seen", 32'(got), 32'd1);
        check("one_latency", 32'(dcyc - c0), 32'(LAT1));
        check("one_golden", 32'(gold1), 32'(k));
        check("one_detected", 32'(det1), 32'(exp_det));
        check("one_detect_cnt", 32'(dc1), 32'(exp_det));
        check("one_cur_fp", 32'(cfp1), 32'd0);
        check("one_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        start1  = 1'b0;
        set_const(8'h3C);
        build_stimulus();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dut_reset", 32'(dut_reset), 32'd1);
        check("rst_dut_enable", 32'(dut_enable), 32'd0);
        check("rst_dut_fp", 32'(dut_fp), 32'hFF);
        check("rst_golden", 32'(golden_val), 32'd0);
        check("rst_cur_fp", 32'(cur_fp), 32'hFF);
        check("rst_detected", 32'(detected), 32'd0);
        check("rst_detect_cnt", 32'(detect_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Constant DUT: nothing detected
        set_const(8'h3C);
        run_campaign(1'b0);
        check("t1_golden", 32'(golden_val), 32'h3C);
        check("t1_detected", 32'(detected), 32'h00);

        // Only fp 3 differs
        set_const(8'h11);
        const_tab[3] = 8'h00;
        run_campaign(1'b0);
        check("t2_detected", 32'(detected), 32'h08);
        check("t2_detect_cnt", 32'(detect_cnt), 32'd1);

        // Counter with enable inverted at fp 0, on both instances
        set_const(8'h00);
        use_cnt  = 1'b1;
        inv_mask = 8'h01;
        run_campaign(1'b0);
        run_one();

        // Reset during the third fault run discards everything
        set_const(8'h11);
        const_tab[0] = 8'h22;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < LAT && !(cur_fp == 8'd2 && busy); i++) @(negedge clk);
        check("t4_reach_fp2", 32'(cur_fp), 32'd2);
        check("t4_partial_det0", 32'(detected[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_dut_reset", 32'(dut_reset), 32'd1);
        check("t4_dut_fp", 32'(dut_fp), 32'hFF);
        check("t4_detected", 32'(detected), 32'd0);
        check("t4_detect_cnt", 32'(detect_cnt), 32'd0);
        check("t4_cur_fp", 32'(cur_fp), 32'hFF);
        check("t4_golden", 32'(golden_val), 32'd0);
        run_campaign(1'b0);

        // start hammered while busy and held during DONE
        rand_cfg();
        run_campaign(1'b1);
        repeat (5) @(negedge clk);
        check("t5_no_restart", 32'(busy), 32'd0);

        // Glitch at RUN cycle 5 of fp 2 only
        set_const(8'h55);
        g_fp   = 8'd2;
        g_cyc  = 8'd5;
        g_mask = 8'h0F;
        run_campaign(1'b0);
`ifdef FC_CYCLE_CMP_EN
        check("t6_detected", 32'(detected), 32'h04);
`else
        check("t6_detected", 32'(detected), 32'h00);
`endif

        // Randomized campaigns
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            run_campaign(r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
